// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial output bundle for the PISO transmitter.
interface piso_shift_tx_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] din;
   logic             load;
   logic             ready;
   logic             dout;
   logic             dout_valid;
   logic             last;

   modport master (
      output din,
      output load,
      input  ready,
      input  dout,
      input  dout_valid,
      input  last
   );

   modport slave (
      input  din,
      input  load,
      output ready,
      output dout,
      output dout_valid,
      output last
   );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: one word in via valid/ready,
// one bit out per clock with per-bit valid and end-of-word strobe.
module piso_shift_tx #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   piso_shift_tx_if.slave bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sr;
   logic             valid_q;
   logic             last_q;
   logic             at_last;
   logic             take;

   assign at_last = (cnt == LAST_CNT);
   assign bus.ready = (state == IDLE) |
                      ((state == SHIFT) & at_last);
   assign take = bus.load & bus.ready;

   // Shifted-out positions fill with 0, so sr is all-zero in IDLE
   assign bus.dout = LSB_FIRST ? sr[0] : sr[WIDTH-1];
   assign bus.dout_valid = valid_q;
   assign bus.last = last_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         sr      <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (take) begin
                  state   <= SHIFT;
                  sr      <= bus.din;
                  cnt     <= '0;
                  valid_q <= 1'b1;
                  last_q  <= (LAST_CNT == '0);
               end
            end
            SHIFT: begin
               if (at_last) begin
                  if (take) begin
                     sr      <= bus.din;
                     cnt     <= '0;
                     valid_q <= 1'b1;
                     last_q  <= (LAST_CNT == '0);
                  end else begin
                     state   <= IDLE;
                     sr      <= '0;
                     cnt     <= '0;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                  end
               end else begin
                  sr      <= LSB_FIRST ? (sr >> 1) : (sr << 1);
                  cnt     <= cnt + 1'b1;
                  valid_q <= 1'b1;
                  last_q  <= ((cnt + 1'b1) == LAST_CNT);
               end
            end
            default: begin
               state   <= IDLE;
               cnt     <= '0;
               sr      <= '0;
               valid_q <= 1'b0;
               last_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
